// File: rtl/timer_pkg.sv
// Shared types and constants for the timer datapath sequencers.
package timer_pkg;

   localparam int TIMER_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LOW,
      HIGH,
      LATCH
   } ctrl_state_t;

   // Width of a counter that must hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Bundle between shift_ctrl, its requester and the external load/shift register.
// Handshake: the requester raises start with data valid; the word is taken on
// any rising clk edge where the controller is idle (busy=0), otherwise start is
// dropped. done pulses for one cycle when the latch strobe has finished.
interface shift_ctrl_if
   import timer_pkg::*;
#(
   parameter int WIDTH = TIMER_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] data;
   logic             busy;
   logic             done;
   logic             sr_S;
   logic             sr_s_in;
   logic [WIDTH-1:0] sr_p_in;
   logic [WIDTH-1:0] sr_q;
   logic             sdat;
   logic             sclk;
   logic             sload;
   ctrl_state_t      dbg_state;

   // Controller side.
   modport slave (
      input  start, data, sr_q,
      output busy, done, sr_S, sr_s_in, sr_p_in, sdat, sclk, sload, dbg_state
   );

   // Requester / register side.
   modport master (
      output start, data, sr_q,
      input  busy, done, sr_S, sr_s_in, sr_p_in, sdat, sclk, sload, dbg_state
   );

endinterface

// File: rtl/shift_ctrl.sv
// Sequencer that loads a word into an external shift-right register and
// clocks it out LSB-first with a divided serial clock and a final latch strobe.
// The register has no enable, so it is held by feeding its own Q back in.
module shift_ctrl
   import timer_pkg::*;
#(
   parameter int WIDTH = TIMER_WIDTH,
   parameter int DIV   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   shift_ctrl_if.slave bus
);

   localparam int BW = cnt_w(WIDTH);
   localparam int PW = cnt_w(DIV);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);

   ctrl_state_t      state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [PW-1:0]    ph_cnt_q, ph_cnt_d;
   logic             sclk_q, sload_q, busy_q, done_q;
   logic             sclk_d, sload_d, busy_d, done_d;
   logic             ph_last, shift_now;

   assign ph_last   = (ph_cnt_q == PH_LAST);
   assign shift_now = (state_q == HIGH) && ph_last;

   // Next state, captured word and the bit/phase counters.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      bit_cnt_d = bit_cnt_q;
      ph_cnt_d  = ph_cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               data_d  = bus.data;
               state_d = LOAD;
            end
         end
         LOAD: begin
            ph_cnt_d  = '0;
            bit_cnt_d = '0;
            state_d   = LOW;
         end
         LOW: begin
            if (ph_last) begin
               ph_cnt_d = '0;
               state_d  = HIGH;
            end else begin
               ph_cnt_d = ph_cnt_q + PW'(1);
            end
         end
         HIGH: begin
            if (ph_last) begin
               ph_cnt_d = '0;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = LATCH;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  state_d   = LOW;
               end
            end else begin
               ph_cnt_d = ph_cnt_q + PW'(1);
            end
         end
         LATCH: begin
            if (ph_last) begin
               ph_cnt_d = '0;
               state_d  = IDLE;
            end else begin
               ph_cnt_d = ph_cnt_q + PW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output flops are decoded from the next state so they switch on state entry.
   always_comb begin
      sclk_d  = (state_d == HIGH);
      sload_d = (state_d == LATCH);
      busy_d  = (state_d != IDLE);
      done_d  = (state_q == LATCH) && (state_d == IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         data_q    <= '0;
         bit_cnt_q <= '0;
         ph_cnt_q  <= '0;
         sclk_q    <= 1'b0;
         sload_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         bit_cnt_q <= bit_cnt_d;
         ph_cnt_q  <= ph_cnt_d;
         sclk_q    <= sclk_d;
         sload_q   <= sload_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Register control: load in LOAD, one shift at the end of HIGH, else hold.
   always_comb begin
      bus.sr_S    = !shift_now;
      bus.sr_s_in = 1'b0;
      bus.sr_p_in = (state_q == LOAD) ? data_q : bus.sr_q;
      bus.sdat    = ((state_q == LOW) || (state_q == HIGH)) ? bus.sr_q[0] : 1'b0;
   end

   assign bus.sclk      = sclk_q;
   assign bus.sload     = sload_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: one DIV=2 and one DIV=1 instance, each driving a
// behavioural model of the load/shift-right register.
module tb_shift_ctrl;
   import timer_pkg::*;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] data;
      int           poke_cyc;
      logic [W-1:0] poke_data;
      logic [W-1:0] exp_stream;
      int           exp_done;
      int           exp_sload;
      int           exp_rises;
      logic [W-1:0] exp_final;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         preload;
   logic [W-1:0] preload_val;
   int           n_cmp = 0;
   int           n_fail = 0;
   vec_t         vecs[5];

   shift_ctrl_if #(.WIDTH(W)) bus2 ();
   shift_ctrl_if #(.WIDTH(W)) bus1 ();

   shift_ctrl #(.WIDTH(W), .DIV(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   shift_ctrl #(.WIDTH(W), .DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   // clock / reset
   always #5 clk = ~clk;

   // register models: parallel load when S=1, shift right with s_in at MSB when S=0
   always @(posedge clk) begin
      if (preload) begin
         bus2.sr_q <= preload_val;
         bus1.sr_q <= preload_val;
      end else begin
         bus2.sr_q <= bus2.sr_S ? bus2.sr_p_in : {bus2.sr_s_in, bus2.sr_q[W-1:1]};
         bus1.sr_q <= bus1.sr_S ? bus1.sr_p_in : {bus1.sr_s_in, bus1.sr_q[W-1:1]};
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one transfer on the DIV=2 instance; caller is at a negedge.
   task automatic run2(input logic [W-1:0] d, input int poke_cyc, input logic [W-1:0] poke_d,
                       output logic [W-1:0] stream, output int done_cyc, output int sload_n,
                       output int rises, output bit busy_ok, output bit sdat_ok,
                       output logic [W-1:0] final_q);
      logic prev_sclk;
      logic held;
      stream    = '0;
      done_cyc  = -1;
      sload_n   = 0;
      rises     = 0;
      busy_ok   = 1'b1;
      sdat_ok   = 1'b1;
      final_q   = '0;
      prev_sclk = 1'b0;
      held      = 1'b0;
      bus2.start = 1'b1;
      bus2.data  = d;
      for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
         @(negedge clk);
         bus2.start = (c == poke_cyc);
         bus2.data  = (c == poke_cyc) ? poke_d : ~d;
         if (bus2.sclk && !prev_sclk) begin
            if (rises < W) stream[rises[3:0]] = bus2.sdat;
            held = bus2.sdat;
            rises++;
         end else if (bus2.sclk && (bus2.sdat !== held)) begin
            sdat_ok = 1'b0;
         end
         prev_sclk = bus2.sclk;
         if (bus2.sload) sload_n++;
         if (bus2.done) begin
            done_cyc = c;
            final_q  = bus2.sr_q;
            if (bus2.busy) busy_ok = 1'b0;
         end else if (!bus2.busy) begin
            busy_ok = 1'b0;
         end
      end
      bus2.start = 1'b0;
   endtask

   initial begin
      logic [W-1:0] stream, final_q, s1, s2, held_q;
      int           done_cyc, sload_n, rises, d1, d2, r1, r2;
      bit           busy_ok, sdat_ok, bad;
      logic         prev;

      vecs[0] = '{16'hA5C3, 0,  16'h0000, 16'hA5C3, 68, 2, 16, 16'h0000};
      vecs[1] = '{16'h0000, 0,  16'h0000, 16'h0000, 68, 2, 16, 16'h0000};
      vecs[2] = '{16'hFFFF, 0,  16'h0000, 16'hFFFF, 68, 2, 16, 16'h0000};
      vecs[3] = '{16'h8001, 0,  16'h0000, 16'h8001, 68, 2, 16, 16'h0000};
      vecs[4] = '{16'h5A5A, 10, 16'h0F0F, 16'h5A5A, 68, 2, 16, 16'h0000};

      bus2.start = 1'b0; bus2.data = '0;
      bus1.start = 1'b0; bus1.data = '0;
      preload = 1'b0; preload_val = '0;

      // reset, then preload the register models with all ones
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outputs", {27'd0, bus2.busy, bus2.done, bus2.sclk, bus2.sload, bus2.sdat}, 32'd0);
      check("rst_state", bus2.dbg_state, IDLE);
      rst_n = 1'b1;
      preload = 1'b1;
      preload_val = 16'hFFFF;
      @(negedge clk);
      preload = 1'b0;

      // idle hold for 20 cycles
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus2.busy || bus2.sclk || bus2.sload || bus2.done || bus1.busy || bus1.sclk || bus1.sload)
            bad = 1'b1;
      end
      check("idle_quiet", {31'd0, bad}, 32'd0);
      check("idle_sr_q_div2", bus2.sr_q, 16'hFFFF);
      check("idle_sr_q_div1", bus1.sr_q, 16'hFFFF);

      // table-driven transfers on the DIV=2 instance
      for (int i = 0; i < 5; i++) begin
         run2(vecs[i].data, vecs[i].poke_cyc, vecs[i].poke_data,
              stream, done_cyc, sload_n, rises, busy_ok, sdat_ok, final_q);
         check($sformatf("v%0d_stream", i), stream, vecs[i].exp_stream);
         check($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
         check($sformatf("v%0d_sload_cycles", i), sload_n, vecs[i].exp_sload);
         check($sformatf("v%0d_sclk_rises", i), rises, vecs[i].exp_rises);
         check($sformatf("v%0d_busy_window", i), {31'd0, busy_ok}, 32'd1);
         check($sformatf("v%0d_sdat_stable", i), {31'd0, sdat_ok}, 32'd1);
         check($sformatf("v%0d_final_sr_q", i), final_q, vecs[i].exp_final);
         @(negedge clk);
         check($sformatf("v%0d_done_one_cycle", i), {30'd0, bus2.done, bus2.busy}, 32'd0);
      end

      // reset during bit 7 (cycles 30..33); 7 shifts of 0x3C96 leave 0x0079
      bus2.start = 1'b1;
      bus2.data  = 16'h3C96;
      for (int c = 1; c <= 31; c++) begin
         @(negedge clk);
         bus2.start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_outputs", {27'd0, bus2.busy, bus2.done, bus2.sclk, bus2.sload, bus2.sdat}, 32'd0);
      check("midrst_state", bus2.dbg_state, IDLE);
      bad = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (bus2.sload || bus2.busy || bus2.done) bad = 1'b1;
      end
      check("midrst_no_sload", {31'd0, bad}, 32'd0);
      check("midrst_sr_q_held", bus2.sr_q, 16'h0079);
      run2(16'hC0DE, 0, 16'h0000, stream, done_cyc, sload_n, rises, busy_ok, sdat_ok, final_q);
      check("after_rst_stream", stream, 16'hC0DE);
      check("after_rst_done_cycle", done_cyc, 68);
      check("after_rst_sload_cycles", sload_n, 2);
      @(negedge clk);

      // DIV=1, start held high through done: back-to-back transfers
      bus1.start = 1'b1;
      bus1.data  = 16'h1E2D;
      d1 = -1; d2 = -1; r1 = 0; r2 = 0; prev = 1'b0; s1 = '0; s2 = '0;
      for (int c = 1; c <= 150 && d2 < 0; c++) begin
         @(negedge clk);
         if (bus1.sclk && !prev) begin
            if (d1 < 0) begin
               if (r1 < W) s1[r1[3:0]] = bus1.sdat;
               r1++;
            end else begin
               if (r2 < W) s2[r2[3:0]] = bus1.sdat;
               r2++;
            end
         end
         prev = bus1.sclk;
         if (bus1.done) begin
            if (d1 < 0) begin
               d1 = c;
            end else begin
               d2 = c;
               bus1.start = 1'b0;
            end
         end
      end
      bus1.start = 1'b0;
      check("div1_first_done", d1, 35);
      check("div1_done_spacing", (d2 < 0) ? -1 : d2 - d1, 35);
      check("div1_rises_1", r1, 16);
      check("div1_rises_2", r2, 16);
      check("div1_stream_1", s1, 16'h1E2D);
      check("div1_stream_2", s2, 16'h1E2D);
      held_q = bus1.sr_q;
      repeat (40) @(negedge clk);
      check("div1_idle_after", {30'd0, bus1.busy, bus1.sload}, 32'd0);
      check("div1_final_sr_q", held_q, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Sequencer for the 16-bit load/shift-right register in the timer datapath. Accepts a 16-bit word on a start strobe, parallel-loads it into the register, then clocks it out LSB-first as a serial stream with a divided serial clock and a final latch pulse, for display drivers of the 74HC595 type. The register has no enable, so this block holds it by reloading its own outputs. `shift_ctrl` and the register are both instantiated by the parent.

## Interface
Parameters:
- `WIDTH`, 16: register width and number of bits per transfer.
- `DIV`, 2: number of `clk` cycles in each `sclk` half-period. Must be ≥1.

Ports:
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `start`, in, 1: transfer request. Sampled only in IDLE.
- `data`, in, WIDTH: word to send. Captured on the cycle `start` is accepted.
- `busy`, out, 1: a transfer is in progress.
- `done`, out, 1: one-cycle completion pulse.
- `sr_S`, out, 1: register mode select. 1 = parallel load, 0 = shift right.
- `sr_s_in`, out, 1: register serial input. Tied to 0, so zeros are filled into the MSB.
- `sr_p_in`, out, WIDTH: register parallel input.
- `sr_q`, in, WIDTH: register outputs (`Q`).
- `sdat`, out, 1: serial data out.
- `sclk`, out, 1: serial clock out.
- `sload`, out, 1: output-latch strobe.

## Operation
- States: IDLE, LOAD, LOW, HIGH, LATCH. State, `data_r`, `bit_cnt` (0..WIDTH-1) and `ph_cnt` (0..DIV-1) are all registered.
- Register control (combinational):
  - In LOAD: `sr_S`=1, `sr_p_in`=`data_r`.
  - On the last HIGH cycle (`ph_cnt`==DIV-1): `sr_S`=0, so the register shifts exactly once.
  - In every other cycle: `sr_S`=1, `sr_p_in`=`sr_q`, which holds the register.
- `sdat` = `sr_q[0]` while in LOW or HIGH, otherwise 0 (combinational).
- IDLE:
  - If `start`=1, capture `data` into `data_r` and go to LOAD.
  - If `start`=0, stay in IDLE.
- LOAD: lasts one cycle, then go to LOW with `ph_cnt`=0 and `bit_cnt`=0.
- LOW: lasts DIV cycles with `sclk`=0, then go to HIGH.
- HIGH: lasts DIV cycles with `sclk`=1.
  - On its last cycle, the register shifts.
  - If `bit_cnt`==WIDTH-1, go to LATCH.
  - Otherwise increment `bit_cnt` and go to LOW.
- LATCH: lasts DIV cycles with `sload`=1 and `sclk`=0, then go to IDLE with `done`=1 for exactly the first IDLE cycle.
- Registered outputs: `sclk`, `sload`, `busy` and `done` are flops decoded from the next state, so they change on the clock edge that enters a state. No combinational path runs from `start` to any of these outputs.

## Timing
- Reset (`rst_n`=0 at an edge), including mid-transfer:
  - State goes to IDLE. `busy`=0, `done`=0, `sclk`=0, `sload`=0, `sdat`=0, counters cleared.
  - A transfer aborted by reset produces no `sload` pulse.
  - The register contents are not cleared; they are held from then on.
- `start` accepted at edge E0:
  - LOAD occupies cycle 1.
  - Bit i uses cycles 2+2·DIV·i through 1+2·DIV·(i+1).
  - LATCH occupies DIV cycles after that.
  - `done`=1 in cycle 2+2·WIDTH·DIV+DIV.
- Total latency from the accept edge to the `done` cycle is 2 + (2·WIDTH+1)·DIV cycles. With defaults, `done` is high in cycle 68.
- `busy`=1 from cycle 1 through the last LATCH cycle inclusive. It falls in the same cycle that `done` rises.
- `start` while `busy`=1 is ignored and not queued.
- `start`=1 in the `done` cycle is accepted, since the block is in IDLE; back-to-back transfers are allowed.
- `sdat` is stable for the whole HIGH phase and changes only after the shift edge, i.e. at LOW entry. A receiver sampling on the `sclk` rising edge gets `data[i]` for bit i.
- DIV=1: each phase is one cycle, giving `sclk` = `clk`/2.

## Structure
- Shared package `timer_pkg` holds the state typedef (`ctrl_state_t`: IDLE, LOAD, LOW, HIGH, LATCH) and `TIMER_WIDTH`=16. `WIDTH` defaults to `TIMER_WIDTH`.
- Counter widths are `$clog2(WIDTH)` for `bit_cnt` and `$clog2(DIV)` for `ph_cnt`, with a minimum of 1.
- No sub-module. The phase counter is inline. The parent connects `sr_*` to the shift register and feeds `Q` back on `sr_q`.

## Test plan
- After reset, with the register model preloaded at 0xFFFF: hold for 20 cycles → `sr_q` stays 0xFFFF, `busy`=0, `sclk`=0, `sload`=0.
- `data`=0xA5C3, DIV=2: `sdat` sampled on each `sclk` rising edge gives 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB-first). `sload` is high for 2 cycles. `done` fires in cycle 68. `sr_q`=0x0000 at the end.
- `start` pulsed in cycle 10 of a busy transfer with a different word → it is ignored, and the original word is sent intact.
- `start` held high through `done` with DIV=1 → the second transfer begins in the `done` cycle. Exactly 16 `sclk` rising edges per transfer, and `done` spacing is 35 cycles.
- `rst_n`=0 during bit 7 → on the next cycle `busy`=0, `sclk`=0, no `sload`. A new `start` then completes a full transfer normally.
